// File: rtl/bcd_conv_pkg.sv
// Shared types, widths and the nibble-correction helper for the shared
// double-dabble binary-to-BCD converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BIN_W = 8;
  localparam int BCD_W = 10;
  localparam int SCR_W = 18;
  localparam int STEPS = 8;
  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
    logic [3:0] res;
    if (nibble >= 4'd5) begin
      res = nibble + 4'd3;
    end else begin
      res = nibble;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/result bundle between the requesters and the shared BCD converter.
interface bcd_conv_arbiter_if;
  import bcd_conv_pkg::*;

  logic [1:0]       req;
  logic [BIN_W-1:0] bin_in0;
  logic [BIN_W-1:0] bin_in1;
  logic [1:0]       ack;
  logic [1:0]       done;
  logic [BCD_W-1:0] bcd_out;
  logic             busy;

  modport master (output req, bin_in0, bin_in1, input ack, done, bcd_out, busy);
  modport slave  (input req, bin_in0, bin_in1, output ack, done, bcd_out, busy);
endinterface

// File: rtl/dd_step.sv
// One double-dabble iteration on the {bcd[9:0], bin[7:0]} scratch:
// correct ones and tens nibbles, then shift the whole word left by one.
module dd_step
  import bcd_conv_pkg::*;
(
  input  logic [SCR_W-1:0] scr_i,
  output logic [SCR_W-1:0] scr_o
);

  logic [3:0] ones_s;
  logic [3:0] tens_s;
  // The hundreds MSB leaves on the shift; it is never set before the last step.
  logic       hund_msb_unused_s;

  assign hund_msb_unused_s = scr_i[SCR_W-1];

  // Nibble corrections followed by the left shift.
  always_comb begin
    ones_s = add3_if_ge5(scr_i[11:8]);
    tens_s = add3_if_ge5(scr_i[15:12]);
    scr_o  = {scr_i[16], tens_s, ones_s, scr_i[7:0], 1'b0};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Two-requester round-robin front end around one iterative 8-bit
// binary-to-BCD engine: capture, eight shift steps, one-cycle done pulse.
module bcd_conv_arbiter
  import bcd_conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  bcd_conv_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  logic [SCR_W-1:0] scr_q, scr_d, step_s;
  logic [2:0]       step_cnt_q, step_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_s;
  logic [BIN_W-1:0] bin_sel_s;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
  logic             busy_q, busy_d;

  dd_step u_dd_step (
    .scr_i (scr_q),
    .scr_o (step_s)
  );

  // Round-robin pick: a lone request wins, a tie goes to the one not served last.
  always_comb begin
    case (bus.req)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ~last_grant_q;
      default: grant_s = 1'b0;
    endcase
    if (grant_s) begin
      bin_sel_s = bus.bin_in1;
    end else begin
      bin_sel_s = bus.bin_in0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (step_cnt_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    scr_d        = scr_q;
    step_cnt_d   = step_cnt_q;
    last_grant_d = last_grant_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    bcd_out_d    = bcd_out_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          scr_d        = {{BCD_W{1'b0}}, bin_sel_s};
          step_cnt_d   = 3'd0;
          last_grant_d = grant_s;
          ack_d        = grant_s ? 2'b10 : 2'b01;
        end else begin
          scr_d = scr_q;
        end
      end
      SHIFT: begin
        scr_d      = step_s;
        step_cnt_d = step_cnt_q + 3'd1;
        if (step_cnt_q == LAST_STEP) begin
          bcd_out_d = step_s[SCR_W-1:BIN_W];
          done_d    = last_grant_q ? 2'b10 : 2'b01;
        end else begin
          done_d = 2'b00;
        end
      end
      DONE:    done_d = 2'b00;
      default: done_d = 2'b00;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scr_q        <= {SCR_W{1'b0}};
      step_cnt_q   <= 3'd0;
      last_grant_q <= 1'b1;
      ack_q        <= 2'b00;
      done_q       <= 2'b00;
      bcd_out_q    <= {BCD_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      scr_q        <= scr_d;
      step_cnt_q   <= step_cnt_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      bcd_out_q    <= bcd_out_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_out_q;
  assign bus.busy    = busy_q;

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares a single iterative 8-bit binary-to-BCD engine (shift-and-add-3, double dabble) between two requesters.
- Arbitrates round-robin and captures the winner's operand.
- Sequences 8 shift steps, then returns a 10-bit packed BCD result (hundreds[9:8], tens[7:4], ones[3:0]) with a per-requester done pulse.
- Multi-cycle, area-cheap replacement for the combinational converter, for use where several display or report paths need BCD.

Parameters:
- BIN_W, 8, binary operand width; only 8 is supported.
- BCD_W, 10, result width (2 + 4 + 4 bits, covers 0..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  2  request per requester; held until its ack
- bin_in0  input  8  operand of requester 0
- bin_in1  input  8  operand of requester 1
- ack  output  2  one-cycle pulse: operand of that requester captured
- done  output  2  one-cycle pulse: bcd_out valid for that requester
- bcd_out  output  10  last result; held until next done
- busy  output  1  high while not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ack=0, done=0, bcd_out=0, busy=0.
  - last_grant=1, so requester 0 wins first.
  - Reset mid-operation aborts the conversion: no done, bcd_out returns to 0.
- States and transitions:
  - IDLE -> SHIFT: on an edge with req!=0. Grant g is the only active request; if both are active, g = !last_grant.
  - On that edge: capture bin_in<g> into scratch {bcd[9:0], bin[7:0]} with bcd=0; step_cnt=0; last_grant=g; ack[g]=1 for the following cycle only.
  - SHIFT: each edge performs one step:
    - add 3 to the ones nibble if it is >=5;
    - add 3 to the tens nibble if it is >=5 (using the corrected values);
    - shift the 18-bit scratch left by 1; step_cnt++.
  - SHIFT -> DONE: after the 8th step edge. On that edge: bcd_out <= scratch[17:8]; done[g]=1 for the DONE cycle.
  - DONE -> IDLE: unconditionally on the next edge.
- Hundreds field is 2 bits and is never corrected (max value 2).
- Latency:
  - ack high in cycle c1; shifts occur at the ends of c1..c8; done high in c9.
  - Earliest next ack is c11, so minimum accept period is 10 cycles per conversion.
- Signal rules:
  - busy=1 in SHIFT and DONE.
  - ack and done are never both high for the same requester in the same cycle; at most one bit of each is high.
- Requester protocol:
  - bin_in is sampled only at the capture edge; changes during SHIFT are ignored.
  - A req still high after its ack is treated as a new request.
  - A req raised while busy waits and is arbitrated in IDLE.
  - Deasserting req before ack withdraws the request, with no side effects.
- Fairness: with both requesters held continuously, grants strictly alternate 0,1,0,1...
- bcd_out changes only on the DONE-entry edge or on reset.

Decomposition:
- Package bcd_conv_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - BIN_W=8, BCD_W=10, SCR_W=18, STEPS=8;
  - function add3_if_ge5(nibble).
- Sub-module dd_step: combinational, one double-dabble iteration on the 18-bit scratch (corrections plus shift).
- Round-robin selection, counter and FSM stay inline in bcd_conv_arbiter.

Test Plan:
- Single request: after reset, req=2'b01, bin_in0=8'hFF -> ack[0] in c1, done[0] in c9, bcd_out=10'h255; busy low at c10.
- Simultaneous requests: req=2'b11, bin_in0=200, bin_in1=199 ->
  - requester 0 served first: bcd_out=10'h200 with done[0];
  - then ack[1] at c11, done[1] at c19 with bcd_out=10'h199.
- Value sweep via requester 1, one at a time: 101->10'h101, 99->10'h099, 1->10'h001, 0->10'h000. Checked against a reference model for all 256 inputs.
- Fairness: hold req=2'b11 for 6 conversions -> grant order 0,1,0,1,0,1, each done 8 cycles after its ack.
- Operand stability: after ack[0] with bin_in0=100, change bin_in0 to 7 mid-SHIFT -> result 10'h100. bcd_out holds its old value until the DONE-entry edge.
- Reset mid-op: assert rst_n=0 during step 4 -> immediately bcd_out=0, busy=0, no done. After release, a pending req=2'b11 grants requester 0 first.
